// File: rtl/uppercase_to_lowercase.sv
// Byte FIFO that folds ASCII 'A'..'Z' to lowercase on the write path.
// Optional macro CONV_COUNT_EN adds a saturating 16-bit conv_count output.
module uppercase_to_lowercase #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready
`ifdef CONV_COUNT_EN
    ,
    output logic [15:0] conv_count
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr, rd_ptr_nxt;
    logic [AW-1:0] wr_ptr, wr_ptr_nxt;
    logic [CW-1:0] count, count_nxt;
    logic          in_ready_nxt, out_valid_nxt;
    logic [7:0]    out_data_nxt, head_nxt;
    logic [7:0]    conv_data;
    logic          is_upper;
    logic          wr_en, rd_en;

    // Write-path character mapping
    always_comb begin
        is_upper  = (in_data >= 8'h41) && (in_data <= 8'h5A);
        conv_data = is_upper ? (in_data | 8'h20) : in_data;
    end

    assign wr_en = in_valid && in_ready;
    assign rd_en = out_valid && out_ready;

    // Next-state: pointers, occupancy, flow-control flags and registered head byte
    always_comb begin
        rd_ptr_nxt    = rd_ptr;
        wr_ptr_nxt    = wr_ptr;
        count_nxt     = count;
        head_nxt      = 8'h00;
        out_data_nxt  = out_data;
        in_ready_nxt  = in_ready;
        out_valid_nxt = out_valid;

        if (wr_en) begin
            wr_ptr_nxt = wr_ptr + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_nxt = rd_ptr + AW'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase

        // The new head is the byte being written only when it lands in the head slot
        if (wr_en && (wr_ptr == rd_ptr_nxt)) begin
            head_nxt = conv_data;
        end else begin
            head_nxt = mem[rd_ptr_nxt];
        end

        if (count_nxt != CW'(0)) begin
            out_data_nxt = head_nxt;
        end
        in_ready_nxt  = (count_nxt < FULL_CNT);
        out_valid_nxt = (count_nxt != CW'(0));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
        end else begin
            rd_ptr    <= rd_ptr_nxt;
            wr_ptr    <= wr_ptr_nxt;
            count     <= count_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
        end
    end

    // Storage holds converted bytes; contents survive reset harmlessly
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_ptr] <= conv_data;
        end
    end

`ifdef CONV_COUNT_EN
    logic [15:0] conv_count_nxt;

    always_comb begin
        conv_count_nxt = conv_count;
        if (wr_en && is_upper && (conv_count != 16'hFFFF)) begin
            conv_count_nxt = conv_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conv_count <= 16'h0000;
        end else begin
            conv_count <= conv_count_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_uppercase_to_lowercase.sv
// Directed self-checking bench for uppercase_to_lowercase (DEPTH=4).
module tb_uppercase_to_lowercase;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
`ifdef CONV_COUNT_EN
    logic [15:0] conv_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    uppercase_to_lowercase #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef CONV_COUNT_EN
        ,
        .conv_count(conv_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] din;
        logic [7:0] dout;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_conv(input logic [7:0] b);
        if (b >= 8'h41 && b <= 8'h5A) return b + 8'd32;
        return b;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Push one byte with out_ready low; returns at the following negedge
    task automatic push(input logic [7:0] b);
        in_valid = 1'b1; in_data = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] fill_exp[5];
        logic [7:0] q[$];
        logic [7:0] b;
        int k;
        int cyc;

        tbl[0]  = '{8'h40, 8'h40};
        tbl[1]  = '{8'h41, 8'h61};
        tbl[2]  = '{8'h5A, 8'h7A};
        tbl[3]  = '{8'h5B, 8'h5B};
        tbl[4]  = '{8'h61, 8'h61};
        tbl[5]  = '{8'hC1, 8'hC1};
        tbl[6]  = '{8'h00, 8'h00};
        tbl[7]  = '{8'h4D, 8'h6D};
        tbl[8]  = '{8'h7A, 8'h7A};
        tbl[9]  = '{8'h60, 8'h60};
        tbl[10] = '{8'hFF, 8'hFF};
        tbl[11] = '{8'h20, 8'h20};

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        do_reset();

        // Reset state
        check("rst_out_valid", 16'(out_valid), 16'h0);
        check("rst_in_ready", 16'(in_ready), 16'h1);
        check("rst_out_data", 16'(out_data), 16'h00);
`ifdef CONV_COUNT_EN
        check("rst_conv_count", conv_count, 16'h0);
`endif

        // Single byte 'A'
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h41;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("single_valid", 16'(out_valid), 16'h1);
        check("single_data", 16'(out_data), 16'h61);
        @(posedge clk);
        @(negedge clk);
        check("single_drained", 16'(out_valid), 16'h0);
        check("single_hold", 16'(out_data), 16'h61);

        // Table stream with continuous accept and drain
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; in_data = tbl[i].din;
            @(posedge clk);
            @(negedge clk);
            check("tbl_valid", 16'(out_valid), 16'h1);
            check($sformatf("tbl_data[%0d]", i), 16'(out_data), 16'(tbl[i].dout));
`ifdef CONV_COUNT_EN
            if (i == 5) check("conv_count_boundary", conv_count, 16'd2);
`endif
        end
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("tbl_empty", 16'(out_valid), 16'h0);
        check("tbl_empty_hold", 16'(out_data), 16'h20);
`ifdef CONV_COUNT_EN
        check("conv_count_tbl", conv_count, 16'd3);
`endif

        // Fill and backpressure
        do_reset();
        fill_exp[0] = 8'h68; fill_exp[1] = 8'h65; fill_exp[2] = 8'h6C;
        fill_exp[3] = 8'h70; fill_exp[4] = 8'h21;
        push(8'h48);
        check("fill_ready1", 16'(in_ready), 16'h1);
        push(8'h45);
        check("fill_ready2", 16'(in_ready), 16'h1);
        push(8'h4C);
        check("fill_ready3", 16'(in_ready), 16'h1);
        push(8'h50);
        check("fill_ready4", 16'(in_ready), 16'h0);
        in_valid = 1'b1; in_data = 8'h21;
        @(posedge clk);
        @(negedge clk);
        check("stall_data_a", 16'(out_data), 16'h68);
        @(posedge clk);
        @(negedge clk);
        check("stall_data_b", 16'(out_data), 16'h68);
        check("stall_ready", 16'(in_ready), 16'h0);
        check("stall_valid", 16'(out_valid), 16'h1);
        out_ready = 1'b1;
        k = 0;
        cyc = 0;
        while (k < 5 && cyc < 20) begin
            if (out_valid) begin
                check($sformatf("drain[%0d]", k), 16'(out_data), 16'(fill_exp[k]));
                k++;
            end
            b = (in_valid && in_ready) ? 8'h01 : 8'h00;
            @(posedge clk);
            @(negedge clk);
            if (b == 8'h01) in_valid = 1'b0;
            cyc++;
        end
        if (k < 5) check("drain_timeout", 16'(k), 16'd5);
        check("drain_empty", 16'(out_valid), 16'h0);

        // Concurrent traffic across pointer wrap, occupancy held at 3
        do_reset();
        q.delete();
        push(8'h51); q.push_back(ref_conv(8'h51));
        push(8'h72); q.push_back(ref_conv(8'h72));
        push(8'h53); q.push_back(ref_conv(8'h53));
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            b = 8'h3E + 8'(i * 5);
            in_data = b;
            check($sformatf("conc_data[%0d]", i), 16'(out_data), 16'(q[0]));
            check("conc_ready", 16'(in_ready), 16'h1);
            @(posedge clk);
            @(negedge clk);
            void'(q.pop_front());
            q.push_back(ref_conv(b));
        end
        in_valid = 1'b0;
        k = 0;
        while (out_valid && k < 8) begin
            check($sformatf("conc_tail[%0d]", k), 16'(out_data), 16'(q[0]));
            void'(q.pop_front());
            k++;
            @(posedge clk);
            @(negedge clk);
        end
        check("conc_occupancy", 16'(k), 16'd3);

        // Reset mid-stream
        do_reset();
        push(8'h41);
        push(8'h42);
        push(8'h43);
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("mid_rst_valid", 16'(out_valid), 16'h0);
        check("mid_rst_ready", 16'(in_ready), 16'h1);
        check("mid_rst_data", 16'(out_data), 16'h00);
`ifdef CONV_COUNT_EN
        check("mid_rst_conv", conv_count, 16'h0);
`endif
        out_ready = 1'b1;
        push(8'h5A);
        check("post_rst_valid", 16'(out_valid), 16'h1);
        check("post_rst_data", 16'(out_data), 16'h7A);
        @(posedge clk);
        @(negedge clk);
        check("post_rst_empty", 16'(out_valid), 16'h0);

`ifdef CONV_COUNT_EN
        // Saturation of the conversion counter
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h4B;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        check("sat_pre", conv_count, 16'hFFFE);
        @(posedge clk);
        @(negedge clk);
        check("sat_reach", conv_count, 16'hFFFF);
        repeat (5) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("sat_hold", conv_count, 16'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uppercase_to_lowercase.md
UPPERCASE_TO_LOWERCASE -- requirements
Module: uppercase_to_lowercase

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered bytes; SHALL be a power of two, 2 to 16.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  producer presents a byte on in_data.
REQ-005 in_data  input  8  ASCII byte from the producer.
REQ-006 in_ready  output  1  block can accept a byte this cycle.
REQ-007 out_valid  output  1  out_data holds a valid converted byte.
REQ-008 out_data  output  8  converted byte, oldest first.
REQ-009 out_ready  input  1  consumer takes out_data this cycle.
REQ-010 conv_count  output  16  number of bytes converted; present only with CONV_COUNT_EN.

Function
REQ-011 Accept: a byte SHALL be written when in_valid and in_ready are both high on a rising edge.
REQ-012 Drain: a byte SHALL be removed when out_valid and out_ready are both high on a rising edge.
REQ-013 Mapping for in_data 0x41..0x5A ('A'..'Z'): the stored byte SHALL be in_data + 0x20, i.e. bit 5 set.
REQ-014 All other values SHALL be stored unchanged, including 0x40, 0x5B, 0x61..0x7A and 0x80..0xFF.
REQ-015 Conversion SHALL be applied on the write path, so the buffer holds converted bytes only.
REQ-016 Order: bytes SHALL leave in acceptance order (FIFO), with no loss and no duplication.
REQ-017 Latency: a byte accepted into an empty block at edge N SHALL appear with out_valid=1 after edge N; minimum latency is one cycle and there is no combinational in-to-out path.
REQ-018 Occupancy: the block SHALL keep an occupancy count 0..DEPTH and wrapping read and write pointers of log2(DEPTH) bits.
REQ-019 Flow control: in_ready SHALL be 1 exactly when occupancy < DEPTH, and SHALL be registered or derived only from state, never from in_valid or out_ready.
REQ-020 out_valid SHALL be 1 exactly when occupancy > 0.
REQ-021 Simultaneous accept and drain: when occupancy is between 1 and DEPTH-1, an accept and a drain on the same edge SHALL leave occupancy unchanged and advance both pointers.
REQ-022 Full: at occupancy DEPTH, in_ready=0 and a drain SHALL reduce occupancy to DEPTH-1; a write on the same edge is not possible.
REQ-023 Empty: at occupancy 0, out_valid=0 and an accept SHALL raise occupancy to 1.
REQ-024 Stall: while out_valid=1 and out_ready=0, out_data SHALL hold stable.
REQ-025 Empty output value: while out_valid=0, out_data SHALL equal the last value driven, or 0x00 after reset.
REQ-026 Pointer wrap: pointers SHALL wrap from DEPTH-1 to 0 without corrupting order.

Reset
REQ-027 When rst=1 at a rising edge, the block SHALL:
- clear occupancy and both pointers;
- drive out_valid=0, out_data=0x00, in_ready=1, and conv_count=0 if present.
REQ-028 Reset mid-operation SHALL discard all buffered bytes; no pre-reset byte SHALL appear after reset.
REQ-029 Handshakes SHALL be ignored while rst=1; buffer contents need not be cleared.

Configuration
REQ-030 With macro CONV_COUNT_EN defined:
- conv_count SHALL exist;
- it SHALL increment by 1 on each accepted byte in 0x41..0x5A;
- it SHALL saturate at 0xFFFF.
REQ-031 Without CONV_COUNT_EN, the conv_count port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Single byte: after reset, in_data=0x41 with in_valid for one cycle, out_ready=1 -> out_valid=1 one cycle later with out_data=0x61, then out_valid=0.
REQ-033 Boundaries: stream 0x40, 0x41, 0x5A, 0x5B, 0x61, 0xC1 -> outputs 0x40, 0x61, 0x7A, 0x5B, 0x61, 0xC1 in order; with CONV_COUNT_EN, conv_count=2.
REQ-034 Fill and backpressure, DEPTH=4: out_ready=0, offer 0x48, 0x45, 0x4C, 0x50, 0x21:
- in_ready=0 after the 4th accept;
- 0x21 is held at the input;
- raising out_ready yields 0x68, 0x65, 0x6C, 0x70, 0x21.
REQ-035 Concurrent traffic: in_valid=1 and out_ready=1 continuously with 3 bytes buffered for 20 cycles -> occupancy stays 3 and the output matches a reference model across pointer wrap.
REQ-036 Reset mid-stream: 3 bytes buffered, rst=1 for one cycle:
- out_valid=0, in_ready=1 and conv_count=0 next cycle;
- a subsequent 0x5A yields only 0x7A.
REQ-037 Saturation, CONV_COUNT_EN only: accept 65,540 bytes of 0x4B -> conv_count stays at 0xFFFF.
